mux_16: RTL and testbench



---
 rtl/mux_16.sv | 40 ++++
 tb/tb_mux_16.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mux_16.sv
// mux_16: two-input word mux for the Hack datapath, with an optional registered copy (MUX16_REG_OUT_EN).
// Latency: y is combinational; y_q/sel_q are one cycle when MUX16_REG_OUT_EN is defined, else combinational.
// Backpressure: none; hold=1 freezes y_q/sel_q, and rst_n low (async) clears them.
module mux_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             hold,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_q
);

    assign y = sel ? b : a;

`ifdef MUX16_REG_OUT_EN
    // Reset dominates hold, and hold dominates capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= 1'b0;
        end else if (!hold) begin
            y_q   <= y;
            sel_q <= sel;
        end
    end
`else
    assign y_q   = y;
    assign sel_q = sel;

    // The port list stays the same in both builds, so the control pins are sunk here.
    logic unused_ctrl;
    assign unused_ctrl = &{1'b0, clk, rst_n, hold};
`endif

endmodule

// File: tb/tb_mux_16.sv
// Bench for mux_16: directed test-plan steps followed by random words, checked against a select-and-capture model.
module tb_mux_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        sel, hold;
    logic [15:0] y, y_q;
    logic        sel_q;

    int total  = 0;
    int passed = 0;

    // Model of the registered copy. It is used only when the register build is selected.
    logic [15:0] mq;
    logic        msq;

    mux_16 #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .hold  (hold),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] pick(input logic [15:0] x0, input logic [15:0] x1, input logic s);
        logic [15:0] src [2];
        src[0] = x0;
        src[1] = x1;
        return src[s];
    endfunction

    function automatic logic [15:0] exp_yq();
`ifdef MUX16_REG_OUT_EN
        return mq;
`else
        return pick(a, b, sel);
`endif
    endfunction

    function automatic logic exp_selq();
`ifdef MUX16_REG_OUT_EN
        return msq;
`else
        return sel;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y"},     {16'h0, y},     {16'h0, pick(a, b, sel)});
        check({tag, ".y_q"},   {16'h0, y_q},   {16'h0, exp_yq()});
        check({tag, ".sel_q"}, {31'h0, sel_q}, {31'h0, exp_selq()});
    endtask

    // Advance one rising edge and leave the bench 1 ns after it. The model captures the pre-edge inputs.
    task automatic tick();
        logic [15:0] nxt;
        logic        nsel;
        nxt  = pick(a, b, sel);
        nsel = sel;
        @(posedge clk);
        if (!rst_n) begin
            mq  = 16'h0;
            msq = 1'b0;
        end else if (!hold) begin
            mq  = nxt;
            msq = nsel;
        end
        #1;
    endtask

    task automatic settle_100ns(input string tag);
        for (int i = 0; i < 10; i++) tick();
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        sel   = 1'b0;
        hold  = 1'b0;
        mq    = 16'h0;
        msq   = 1'b0;
        tick();
        tick();
        check_all("reset");

        rst_n = 1'b1;
        a = 16'h0000; b = 16'hFFFF; sel = 1'b0;
        settle_100ns("zero_sel0");
        sel = 1'b1;
        settle_100ns("ones_sel1");
        a = 16'hAAAA; b = 16'h5555; sel = 1'b0;
        settle_100ns("alt_sel0");
        sel = 1'b1;
        settle_100ns("alt_sel1");

        // Assert reset between edges while y_q holds a nonzero value.
        #2;
        rst_n = 1'b0;
`ifdef MUX16_REG_OUT_EN
        mq  = 16'h0;
        msq = 1'b0;
`endif
        #1;
        check_all("midreset");
        tick();
        check_all("in_reset");
        rst_n = 1'b1;

        // Latency: switch sel just after an edge.
        a = 16'h1234; b = 16'hBEEF; sel = 1'b0;
        tick();
        check_all("lat_pre");
        sel = 1'b1;
        #1;
        check_all("lat_sel_toggle");
        tick();
        check_all("lat_edge");

        hold = 1'b1;
        sel  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("hold");
        end
        hold = 1'b0;
        tick();
        check_all("hold_release");

        for (int i = 0; i < 40; i++) begin
            a    = 16'($urandom);
            b    = 16'($urandom);
            sel  = 1'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            #1;
            check_all("rand_pre");
            tick();
            check_all("rand_post");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
